// File: rtl/dircc_counter_send_handler.sv
// DiRCC counter send handler: emits one tick packet per granted send slot and writes back rts-1.
// Optional send watchdog is compiled in with `define DIRCC_SEND_TIMEOUT_EN.
`timescale 1ns/1ps

package dircc_counter_pkg;

  localparam logic [31:0] DIRCC_STATE_DONE    = 32'h0000_0001;
  localparam logic [31:0] DIRCC_STATE_STOPPED = 32'h0000_0002;

  // user_state packs rts in [31:16] and count in [15:0]
  typedef struct packed {
    logic [31:0] user_state;
    logic [31:0] dircc_state;
    logic [31:0] dircc_state_extra;
  } device_state_t;

  typedef struct packed {
    logic [31:0] src_address;
    logic [31:0] tick;
  } packet_data_t;

endpackage

module dircc_counter_send_handler
  import dircc_counter_pkg::*;
#(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int SEND_TIMEOUT      = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic                         send_request,
  input  device_state_t                read_state,
  output packet_data_t                 packet_out,
  output logic                         packet_out_valid,
  input  logic                         packet_out_ready,
  output device_state_t                write_state,
  output logic                         write_state_valid,
  output logic                         send_done,
  output logic                         send_skipped,
  output logic                         send_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_SKIP   = 2'd3;

  logic [1:0]                   state_q, state_d;
  device_state_t                snap_q, snap_d;
  logic [ADDRESS_MEM_WIDTH-1:0] addr_q, addr_d;
  logic                         err_q, err_d;

  logic        handshake;
  logic        wd_expire;
  logic [15:0] rts_snap;
  logic [15:0] count_snap;
  logic [15:0] rts_next;

  assign handshake  = (state_q == S_SEND) && packet_out_ready;
  assign rts_snap   = snap_q.user_state[31:16];
  assign count_snap = snap_q.user_state[15:0];
  // Only evaluated in COMMIT after a successful send, where rts_snap >= 1
  assign rts_next   = rts_snap - 16'd1;

`ifdef DIRCC_SEND_TIMEOUT_EN
  localparam int WD_RAW = $clog2(SEND_TIMEOUT + 1);
  localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(SEND_TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts cycles spent in SEND; cleared everywhere else so each attempt starts at zero
  always_comb begin
    wd_d = '0;
    if (state_q == S_SEND) wd_d = wd_q + WD_W'(1);
  end

  assign wd_expire = (state_q == S_SEND) && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (send_request) begin
          snap_d  = read_state;
          addr_d  = address;
          err_d   = 1'b0;
          state_d = (read_state.user_state[31:16] != 16'd0) ? S_SEND : S_SKIP;
        end
      end
      S_SEND: begin
        // A handshake on the watchdog's final edge still counts as a successful send
        if (handshake) begin
          state_d = S_COMMIT;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_SKIP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // The snapshot registers are reset too, so packet_out/write_state read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign packet_out_valid  = (state_q == S_SEND);
  assign write_state_valid = (state_q == S_COMMIT) && !err_q;
  assign send_done         = (state_q == S_COMMIT) || (state_q == S_SKIP);
  assign send_skipped      = (state_q == S_SKIP);

`ifdef DIRCC_SEND_TIMEOUT_EN
  assign send_error = (state_q == S_COMMIT) && err_q;
`else
  assign send_error = 1'b0;
`endif

  always_comb begin
    packet_out = '0;
    if (state_q == S_SEND) begin
      packet_out.src_address = 32'(addr_q);
      packet_out.tick        = {16'h0000, count_snap};
    end
  end

  always_comb begin
    write_state = '0;
    if (write_state_valid) begin
      write_state.user_state        = {rts_next, count_snap};
      write_state.dircc_state_extra = snap_q.dircc_state_extra;
      if ((rts_next == 16'd0) && ((snap_q.dircc_state & DIRCC_STATE_DONE) != 32'd0))
        write_state.dircc_state = DIRCC_STATE_DONE | DIRCC_STATE_STOPPED;
      else
        write_state.dircc_state = snap_q.dircc_state;
    end
  end

endmodule

// File: tb/tb_dircc_counter_send_handler.sv
// Scoreboard bench for dircc_counter_send_handler: directed requests push expectations,
// a negedge monitor pops and compares packets, writebacks and done strobes with their cycle.
`timescale 1ns/1ps

module tb_dircc_counter_send_handler;
  import dircc_counter_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   address;
  logic          send_request;
  device_state_t read_state;
  packet_data_t  packet_out;
  logic          packet_out_valid;
  logic          packet_out_ready;
  device_state_t write_state;
  logic          write_state_valid;
  logic          send_done;
  logic          send_skipped;
  logic          send_error;

  always #5 clk = ~clk;

  dircc_counter_send_handler #(
    .ADDRESS_MEM_WIDTH(32),
    .SEND_TIMEOUT     (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .address          (address),
    .send_request     (send_request),
    .read_state       (read_state),
    .packet_out       (packet_out),
    .packet_out_valid (packet_out_valid),
    .packet_out_ready (packet_out_ready),
    .write_state      (write_state),
    .write_state_valid(write_state_valid),
    .send_done        (send_done),
    .send_skipped     (send_skipped),
    .send_error       (send_error)
  );

  typedef struct { packet_data_t pkt; int cyc; } pkt_exp_t;
  typedef struct { device_state_t st; int cyc; } ws_exp_t;
  typedef struct { logic skipped; logic err; int cyc; } done_exp_t;

  pkt_exp_t  pkt_q[$];
  ws_exp_t   ws_q[$];
  done_exp_t done_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic device_state_t mk(input logic [15:0] rts, input logic [15:0] cnt,
                                        input logic [31:0] ds, input logic [31:0] ex);
    device_state_t s;
    s.user_state        = {rts, cnt};
    s.dircc_state       = ds;
    s.dircc_state_extra = ex;
    return s;
  endfunction

  function automatic packet_data_t mkp(input logic [31:0] a, input logic [15:0] cnt);
    packet_data_t p;
    p.src_address = a;
    p.tick        = {16'h0000, cnt};
    return p;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge
  packet_data_t prev_pkt;
  logic         prev_stall = 1'b0;
  pkt_exp_t     pe;
  ws_exp_t      we;
  done_exp_t    de;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && packet_out_valid)
        check("pkt_stable", 96'(packet_out), 96'(prev_pkt));
`ifndef DIRCC_SEND_TIMEOUT_EN
      if (prev_stall && !packet_out_valid)
        check("valid_held", 96'(packet_out_valid), 96'd1);
`endif
      if (packet_out_valid && packet_out_ready) begin
        if (pkt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt: got %h expected none (cycle %0d)", packet_out, cyc);
        end else begin
          pe = pkt_q.pop_front();
          check("pkt_data", 96'(packet_out), 96'(pe.pkt));
          check("pkt_cycle", 96'(cyc), 96'(pe.cyc));
        end
      end
      if (write_state_valid) begin
        if (ws_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got %h expected none (cycle %0d)", write_state, cyc);
        end else begin
          we = ws_q.pop_front();
          check("wb_state", 96'(write_state), 96'(we.st));
          check("wb_cycle", 96'(cyc), 96'(we.cyc));
        end
      end
      if (send_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got 1 expected none (cycle %0d)", cyc);
        end else begin
          de = done_q.pop_front();
          check("done_skipped", 96'(send_skipped), 96'(de.skipped));
          check("done_error", 96'(send_error), 96'(de.err));
          check("done_cycle", 96'(cyc), 96'(de.cyc));
        end
      end
      prev_stall = packet_out_valid && !packet_out_ready;
      prev_pkt   = packet_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request for one edge; n returns the edge index that sampled it
  task automatic request(input device_state_t s, input logic [31:0] a, output int n);
    read_state   = s;
    address      = a;
    send_request = 1'b1;
    tick();
    n            = cyc;
    send_request = 1'b0;
  endtask

  int n;

  initial begin
    reset            = 1'b1;
    address          = '0;
    send_request     = 1'b0;
    read_state       = '0;
    packet_out_ready = 1'b0;
    #1;
    check("rst_pkt_valid", 96'(packet_out_valid), 96'd0);
    check("rst_wb_valid", 96'(write_state_valid), 96'd0);
    check("rst_done", 96'(send_done), 96'd0);
    check("rst_skipped", 96'(send_skipped), 96'd0);
    check("rst_error", 96'(send_error), 96'd0);
    check("rst_pkt", 96'(packet_out), 96'd0);
    check("rst_wb", 96'(write_state), 96'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic send with ready held high: rts=3, count=7
    packet_out_ready = 1'b1;
    request(mk(16'd3, 16'd7, 32'h0, 32'hA5A5_0001), 32'h100, n);
    pkt_q.push_back('{mkp(32'h100, 16'd7), n});
    ws_q.push_back('{mk(16'd2, 16'd7, 32'h0, 32'hA5A5_0001), n + 1});
    done_q.push_back('{1'b0, 1'b0, n + 1});
    tick(); tick();

    // Back-to-back at full rate: rts=1 without DONE passes dircc_state through
    request(mk(16'd1, 16'hFFFF, 32'h10, 32'h0), 32'h200, n);
    pkt_q.push_back('{mkp(32'h200, 16'hFFFF), n});
    ws_q.push_back('{mk(16'd0, 16'hFFFF, 32'h10, 32'h0), n + 1});
    done_q.push_back('{1'b0, 1'b0, n + 1});
    tick(); tick();

    // rts=0: skip path, no packet and no writeback
    request(mk(16'd0, 16'd3, DIRCC_STATE_DONE, 32'h0), 32'h300, n);
    done_q.push_back('{1'b1, 1'b0, n});
    tick();

    // Stall ready for five cycles; rts reaches 0 with DONE set
    packet_out_ready = 1'b0;
    request(mk(16'd1, 16'd42, 32'h101, 32'h7), 32'h400, n);
    pkt_q.push_back('{mkp(32'h400, 16'd42), n + 5});
    ws_q.push_back('{mk(16'd0, 16'd42, 32'h3, 32'h7), n + 6});
    done_q.push_back('{1'b0, 1'b0, n + 6});
    repeat (5) tick();
    packet_out_ready = 1'b1;
    tick(); tick();

    // Requests during SEND and COMMIT are ignored; read_state changes after snapshot too
    packet_out_ready = 1'b0;
    request(mk(16'd2, 16'd5, 32'h0, 32'h0), 32'h500, n);
    pkt_q.push_back('{mkp(32'h500, 16'd5), n + 2});
    ws_q.push_back('{mk(16'd1, 16'd5, 32'h0, 32'h0), n + 3});
    done_q.push_back('{1'b0, 1'b0, n + 3});
    read_state   = mk(16'd9, 16'd99, 32'h1, 32'h0);
    send_request = 1'b1;
    tick();
    send_request = 1'b0;
    tick();
    packet_out_ready = 1'b1;
    send_request     = 1'b1;
    tick(); tick();
    send_request = 1'b0;
    tick();

    // Largest rts: no wrap, DONE kept as-is because new rts is non-zero
    request(mk(16'hFFFF, 16'd0, DIRCC_STATE_DONE, 32'hDEAD_BEEF), 32'h700, n);
    pkt_q.push_back('{mkp(32'h700, 16'd0), n});
    ws_q.push_back('{mk(16'hFFFE, 16'd0, DIRCC_STATE_DONE, 32'hDEAD_BEEF), n + 1});
    done_q.push_back('{1'b0, 1'b0, n + 1});
    tick(); tick();

    // Reset during SEND abandons the packet with no writeback
    packet_out_ready = 1'b0;
    request(mk(16'd4, 16'd11, 32'h0, 32'h0), 32'h800, n);
    tick();
    check("pre_reset_valid", 96'(packet_out_valid), 96'd1);
    reset = 1'b1;
    #1;
    check("reset_valid_drop", 96'(packet_out_valid), 96'd0);
    check("reset_wb_valid", 96'(write_state_valid), 96'd0);
    check("reset_done", 96'(send_done), 96'd0);
    tick(); tick();
    reset            = 1'b0;
    packet_out_ready = 1'b1;
    repeat (4) tick();

`ifdef DIRCC_SEND_TIMEOUT_EN
    // Watchdog with SEND_TIMEOUT=4: valid for 4 cycles, then error done, no writeback
    packet_out_ready = 1'b0;
    request(mk(16'd2, 16'd9, 32'h0, 32'h0), 32'h900, n);
    done_q.push_back('{1'b0, 1'b1, n + 4});
    repeat (3) tick();
    check("to_valid_last", 96'(packet_out_valid), 96'd1);
    tick();
    check("to_valid_drop", 96'(packet_out_valid), 96'd0);
    repeat (3) tick();
`endif

    repeat (3) tick();
    check("pkt_q_empty", 96'(pkt_q.size()), 96'd0);
    check("ws_q_empty", 96'(ws_q.size()), 96'd0);
    check("done_q_empty", 96'(done_q.size()), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
